// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic ARM instructions into 32-bit words, streams them
// into consecutive instruction-memory slots and closes each session with a halt word.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       finish,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 kind,
  input  logic [3:0]                 cond,
  input  logic                       s_bit,
  input  logic                       imm_sel,
  input  logic [3:0]                 rd,
  input  logic [3:0]                 rn,
  input  logic [3:0]                 rm,
  input  logic [4:0]                 shamt,
  input  logic [23:0]                imm,
  output logic                       we,
  output logic [31:0]                waddr,
  output logic [31:0]                wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int          CW        = $clog2(DEPTH + 1);
  localparam logic [31:0] HALT_WORD = 32'hEAFF_FFFE;

  typedef enum logic [1:0] {IDLE, LOAD, HALT_WR, DONE} state_e;

  state_e          state_q, state_d;
  logic            haltPending_q, haltPending_d;
  logic            we_q, we_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [CW-1:0]   count_q, count_d;

  logic [CW-1:0]   slot;
  logic [31:0]     slotAddr;
  logic            legal;
  logic            accept;
  logic [31:0]     encWord;
  logic [3:0]      cmd;
  logic            dpS;
  logic [3:0]      dpRd;
  logic [3:0]      dpRn;
  logic [11:0]     src2;

  // A word already sitting in the write stage owns the slot at count_q.
  assign slot     = count_q + CW'(we_q);
  assign slotAddr = BASE_ADDR + (32'(slot) << 2);
  assign in_ready = (state_q == LOAD) && (32'(slot) < 32'(DEPTH - 1)) && !haltPending_q;

  always_comb begin
    legal   = 1'b1;
    cmd     = 4'b0000;
    dpS     = s_bit;
    dpRd    = rd;
    dpRn    = rn;
    src2    = imm_sel ? {4'b0000, imm[7:0]} : {shamt, 2'b00, 1'b0, rm};
    encWord = 32'h0000_0000;
    case (kind)
      4'd0: cmd = 4'b0000;
      4'd1: cmd = 4'b0010;
      4'd2: cmd = 4'b0100;
      4'd3: cmd = 4'b1100;
      4'd4: begin
        cmd  = 4'b1000;
        dpS  = 1'b1;
        dpRd = 4'd0;
      end
      4'd5: begin
        cmd  = 4'b1010;
        dpS  = 1'b1;
        dpRd = 4'd0;
      end
      4'd6: begin
        cmd  = 4'b1101;
        dpRn = 4'd0;
      end
      default: ;
    endcase
    if (kind <= 4'd6) begin
      encWord = {cond, 2'b00, imm_sel, cmd, dpS, dpRn, dpRd, src2};
    end else if (kind == 4'd7 || kind == 4'd8) begin
      encWord = {cond, 2'b01, ~imm_sel, 4'b1100, (kind == 4'd7), rn, rd,
                 imm_sel ? imm[11:0] : src2};
    end else if (kind == 4'd9) begin
      encWord = {cond, 4'b1010, imm};
    end else begin
      legal = 1'b0;
    end
  end

  // A handshake in the finish cycle owns the write stage first, so the halt waits a cycle.
  always_comb begin
    state_d       = state_q;
    haltPending_d = haltPending_q;
    we_d          = 1'b0;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    count_d       = count_q + CW'(we_q);
    accept        = 1'b0;
    if (start) begin
      state_d       = LOAD;
      haltPending_d = 1'b0;
      count_d       = '0;
      err_d         = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          accept = in_valid && in_ready;
          if (accept && legal) begin
            we_d    = 1'b1;
            waddr_d = slotAddr;
            wdata_d = encWord;
          end
          if (accept && !legal) err_d = 1'b1;
          if (finish) begin
            state_d = HALT_WR;
            if (accept && legal) begin
              haltPending_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              waddr_d = slotAddr;
              wdata_d = HALT_WORD;
            end
          end
        end
        HALT_WR: begin
          if (haltPending_q) begin
            we_d          = 1'b1;
            waddr_d       = slotAddr;
            wdata_d       = HALT_WORD;
            haltPending_d = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      haltPending_q <= 1'b0;
      we_q          <= 1'b0;
      waddr_q       <= 32'h0000_0000;
      wdata_q       <= 32'h0000_0000;
      err_q         <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      haltPending_q <= haltPending_d;
      we_q          <= we_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      err_q         <= err_d;
      count_q       <= count_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = (state_q == LOAD) || (state_q == HALT_WR);
  assign done  = (state_q == DONE);
  assign err   = err_q;
  assign count = count_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Sequential ARM instruction encoder and loader; it performs the inverse of the control decoder.
- Accepts one symbolic instruction per valid/ready handshake and packs it into a 32-bit ARM word.
- Writes the words to consecutive instruction-memory addresses starting at `BASE_ADDR`.
- On `finish` it appends a halt word (`B .`, 0xEAFFFFFE).
- Sits between the boot/test stimulus source and the instruction-memory write port; it is idle during normal execution.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written.
- `DEPTH`, 64: words available. One slot is always reserved for the halt word.
- `clk`  in  1  clock. Single clock domain; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins or restarts a load session.
- `finish`  in  1  one-cycle pulse; ends the session and appends the halt word.
- `in_valid`  in  1  instruction fields are valid.
- `in_ready`  out  1  encoder accepts fields this cycle.
- `kind`  in  4  instruction kind: 0 AND, 1 SUB, 2 ADD, 3 ORR, 4 TST, 5 CMP, 6 MOV, 7 LDR, 8 STR, 9 B. Codes 10–15 are illegal.
- `cond`  in  4  condition field, copied to bits [31:28].
- `s_bit`  in  1  set-flags bit for AND/SUB/ADD/ORR/MOV.
- `imm_sel`  in  1  1 = immediate operand, 0 = register operand.
- `rd`, `rn`, `rm`  in  4 each  register numbers.
- `shamt`  in  5  LSL amount; used for register operands.
- `imm`  in  24  immediate. DP uses [7:0], memory uses [11:0], B uses [23:0].
- `we`  out  1  instruction-memory write enable.
- `waddr`  out  32  byte address of the write.
- `wdata`  out  32  encoded word.
- `busy`  out  1  high in LOAD and HALT_WR.
- `done`  out  1  high in DONE.
- `err`  out  1  sticky flag; an illegal kind was consumed.
- `count`  out  $clog2(DEPTH+1)  words written in this session, halt word included.

## Operation
- FSM states: IDLE, LOAD, HALT_WR, DONE.
  - `start` in any state: go to LOAD, clear `count` and `err`, and squash any pending write (`we` stays 0 on the next cycle).
  - LOAD + `finish`: go to HALT_WR.
  - HALT_WR: issue the halt write, then go to DONE.
  - DONE: hold until `start`.
- `in_ready` = (state==LOAD) & (count < DEPTH-1) & !finish_pending. It is combinational from registered state only.
- Accepted fields are encoded and registered into the write stage. The write address is BASE_ADDR + 4*count; `count` increments when `we` fires.
- Data-processing encoding:
  - Word layout: cond | 00 | I | cmd | S | Rn | Rd | Src2.
  - cmd values: AND 0000, SUB 0010, ADD 0100, ORR 1100, TST 1000, CMP 1010, MOV 1101.
  - Immediate Src2 = {4'b0000 rotate, imm[7:0]}.
  - Register Src2 = {shamt, 2'b00 LSL, 1'b0, Rm}.
  - TST/CMP force S=1 and Rd=0. MOV forces Rn=0.
- Memory encoding:
  - Word layout: cond | 01 | ~imm_sel | P=1 | U=1 | B=0 | W=0 | L | Rn | Rd | offset.
  - L=1 for LDR, L=0 for STR.
  - offset = imm[11:0], or the register Src2 form when `imm_sel`=0.
- Branch encoding: cond | 1010 | imm[23:0].
- Illegal kind: the handshake completes, nothing is written, `err` sets, and `count` is unchanged.

## Timing
- Reset values: state IDLE, `we`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0, `err`=0, `count`=0, `in_ready`=0.
- Latency: a handshake in cycle N produces `we`=1 with the word in cycle N+1. Throughput is one word per cycle.
- Same-cycle handshake and `finish`: the instruction is written at N+1 and the halt at N+2.
- A lone `finish` at N writes the halt at N+1. `done` rises at N+2.
- Full: when `count` reaches DEPTH-1, `in_ready` drops. The halt word always fits at BASE_ADDR + 4*(DEPTH-1).
- `finish` outside LOAD is ignored. `in_valid` outside LOAD is ignored.
- `reset` mid-session: all state returns to reset values at the next edge, and no write occurs.

## Test plan
- ADD R1,R2,#5 (kind 2, cond E, imm_sel 1, S 0) → `we` at N+1, `waddr`=0x0, `wdata`=0xE2821005.
- CMP R3,R4 (kind 5, cond E, imm_sel 0) followed by MOV R5,R6,LSL #2 → 0xE1530004 at 0x0, then 0xE1A05106 at 0x4 on back-to-back cycles.
- LDR R0,[R1,#8] followed by STR R0,[R1,#8] → 0xE5910008, then 0xE5810008.
- B, cond 0, imm 0xFFFFFD, then `finish` → 0x0AFFFFFD at 0x0, 0xEAFFFFFE at 0x4, `done`=1, `count`=2.
- DEPTH=4: stream 5 instructions → 3 accepted, `in_ready`=0 afterwards; `finish` → halt at 0xC, `count`=4.
- kind=12 mid-stream → no write, `err`=1, next legal word lands at the unchanged address; a later `start` clears `err` and `count`.
